// File: rtl/seg_scan_if.sv
// Segment-scanner bus: two active-high digit patterns in, multiplexed
// active-low segment bus, anodes and frame pulse out.
interface seg_scan_if;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    // The display decoder (or a bench) drives the patterns and watches the pins.
    modport master (
        output seg_tens,
        output seg_ones,
        input  seg,
        input  an,
        input  frame_start
    );

    modport slave (
        input  seg_tens,
        input  seg_ones,
        output seg,
        output an,
        output frame_start
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Two-digit time-multiplexed seven-segment scanner with dark guard gaps and
// per-frame snapshots. Optional macro LEADING_ZERO_BLANK_EN blanks a leading tens zero.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int MAX_N = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W = $clog2(MAX_N) + 1;
    localparam logic [CNT_W-1:0] LIT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DARK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0] ZERO_PATTERN = 7'b0111111;

    typedef enum logic [1:0] {GAP_T, ONES, GAP_O, TENS} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [6:0]       snap_tens_reg;
    logic [6:0]       snap_ones_reg;
    logic [6:0]       seg_reg;
    logic [3:0]       an_reg;
    logic             frame_start_reg;

    logic             lit_state;
    logic             dwell_done;
    logic             tens_dark;

    assign lit_state  = (state_reg == ONES) || (state_reg == TENS);
    assign dwell_done = (cnt_reg == (lit_state ? LIT_LAST : DARK_LAST));

`ifdef LEADING_ZERO_BLANK_EN
    assign tens_dark = (snap_tens_reg == ZERO_PATTERN);
`else
    assign tens_dark = 1'b0;
`endif

    // Outputs are loaded together with the next state so they switch on the
    // same edge as the state; the ONES entry uses the live inputs because the
    // snapshot is being taken on that very edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= GAP_T;
            cnt_reg         <= '0;
            snap_tens_reg   <= '0;
            snap_ones_reg   <= '0;
            seg_reg         <= 7'b1111111;
            an_reg          <= 4'b1111;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= 1'b0;
            if (dwell_done) begin
                cnt_reg <= '0;
                case (state_reg)
                    GAP_T: begin
                        state_reg       <= ONES;
                        snap_tens_reg   <= bus.seg_tens;
                        snap_ones_reg   <= bus.seg_ones;
                        an_reg          <= 4'b1110;
                        seg_reg         <= ~bus.seg_ones;
                        frame_start_reg <= 1'b1;
                    end
                    ONES: begin
                        state_reg <= GAP_O;
                        an_reg    <= 4'b1111;
                        seg_reg   <= 7'b1111111;
                    end
                    GAP_O: begin
                        state_reg <= TENS;
                        if (tens_dark) begin
                            an_reg  <= 4'b1111;
                            seg_reg <= 7'b1111111;
                        end else begin
                            an_reg  <= 4'b1101;
                            seg_reg <= ~snap_tens_reg;
                        end
                    end
                    default: begin
                        state_reg <= GAP_T;
                        an_reg    <= 4'b1111;
                        seg_reg   <= 7'b1111111;
                    end
                endcase
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.seg         = seg_reg;
    assign bus.an          = an_reg;
    assign bus.frame_start = frame_start_reg;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with REFRESH_DIV = 4, BLANK_CYCLES = 2:
// each frame's expected 12 cycles are queued when its patterns are driven.
module tb_seg_scan_mux;
    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int FRAME_LEN    = 2 * (REFRESH_DIV + BLANK_CYCLES);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   frame_no = 0;
    exp_t exp_q[$];

    seg_scan_if sif ();

    seg_scan_mux #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (frame %0d, t=%0t)", tag, got, exp, frame_no, $time);
        end
    endtask

    // Expected frame built from the timing description: 2 dark, 4 ones, 2 dark, 4 tens.
    task automatic push_frame(input logic [6:0] t, input logic [6:0] o);
        exp_t e;
        for (int i = 0; i < FRAME_LEN; i++) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
            e.fs  = 1'b0;
            if (i >= BLANK_CYCLES && i < BLANK_CYCLES + REFRESH_DIV) begin
                e.an  = 4'b1110;
                e.seg = ~o;
                e.fs  = (i == BLANK_CYCLES);
            end else if (i >= 2 * BLANK_CYCLES + REFRESH_DIV) begin
`ifdef LEADING_ZERO_BLANK_EN
                if (t != 7'b0111111) begin
                    e.an  = 4'b1101;
                    e.seg = ~t;
                end
`else
                e.an  = 4'b1101;
                e.seg = ~t;
`endif
            end
            exp_q.push_back(e);
        end
    endtask

    // Called while the first dark cycle of a frame is being observed.
    // chg_idx: cycle at which seg_ones switches to o_new (-1 = none).
    // rst_idx: cycle after which a one-cycle reset is applied (-1 = none).
    task automatic run_frame(input logic [6:0] t, input logic [6:0] o, input int chg_idx,
                             input logic [6:0] o_new, input int rst_idx);
        exp_t e;
        int   dark_cnt;
        int   both_cnt;
        sif.seg_tens = t;
        sif.seg_ones = o;
        push_frame(t, (chg_idx >= 0 && chg_idx < BLANK_CYCLES) ? o_new : o);
        dark_cnt = 0;
        both_cnt = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == chg_idx) sif.seg_ones = o_new;
            e = exp_q.pop_front();
            check("an", 32'(sif.an), 32'(e.an));
            check("seg", 32'(sif.seg), 32'(e.seg));
            check("frame_start", 32'(sif.frame_start), 32'(e.fs));
            if (sif.an == 4'b1111) dark_cnt++;
            if (sif.an[1:0] == 2'b00) both_cnt++;
            if (i == rst_idx) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_q.delete();
                check("rst_an", 32'(sif.an), 32'h0000000f);
                check("rst_seg", 32'(sif.seg), 32'h0000007f);
                check("rst_fs", 32'(sif.frame_start), 32'h0);
                $display("frame %0d: reset at cycle %0d, display blanked", frame_no, i);
                frame_no++;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("dark_cycles", 32'(dark_cnt), 32'd4);
        check("two_anodes_low", 32'(both_cnt), 32'd0);
        $display("frame %0d: tens=%07b ones=%07b dark=%0d", frame_no, t, o, dark_cnt);
        frame_no++;
    endtask

    initial begin
        sif.seg_tens = 7'b0000110;
        sif.seg_ones = 7'b1111111;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_an", 32'(sif.an), 32'h0000000f);
        check("reset_seg", 32'(sif.seg), 32'h0000007f);
        check("reset_fs", 32'(sif.frame_start), 32'h0);
        rst = 1'b0;

        // 18 followed by a mid-ONES change to 7 that must wait a frame.
        run_frame(7'b0000110, 7'b1111111, -1, 7'b0000000, -1);
        run_frame(7'b0000110, 7'b1111111, 3, 7'b0000111, -1);
        run_frame(7'b0000110, 7'b0000111, -1, 7'b0000000, -1);
        // Change just before the snapshot edge is captured.
        run_frame(7'b1011011, 7'b0000111, 1, 7'b1100110, -1);
        // Reset during TENS, then a fresh frame from the top.
        run_frame(7'b1011011, 7'b1100110, -1, 7'b0000000, 9);
        run_frame(7'b1001111, 7'b1101101, -1, 7'b0000000, -1);
        // Leading-zero tens digit over three consecutive frames.
        for (int f = 0; f < 3; f++)
            run_frame(7'b0111111, 7'b1101101, -1, 7'b0000000, -1);
        // Randomised patterns for a couple more frames.
        for (int f = 0; f < 2; f++)
            run_frame(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), -1, 7'b0000000, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
